// File: rtl/icache_tag_pkg.sv
`default_nettype none
// ============================================================================
// icache_tag_pkg : default sizes, flush FSM states and way-tag type
// Rev 1.0
// ============================================================================
package icache_tag_pkg;

  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_NUM_WAYS   = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  typedef logic [DEF_DATA_WIDTH-1:0] way_tag_t;

endpackage
`default_nettype wire

// File: rtl/icache_tag_way.sv
`default_nettype none
// ============================================================================
// icache_tag_way : one way -- tag array, valid vector, optional parity (TAG_PARITY_EN)
// Rev 1.0
// ============================================================================
module icache_tag_way #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rtag,
`ifdef TAG_PARITY_EN
  output logic                  rperr,
`endif
  output logic                  rvalid
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] tags [RAM_DEPTH];
  logic [RAM_DEPTH-1:0]  valid;

  // Tag storage is deliberately left unreset; only the valid bits matter.
  always_ff @(posedge clk) begin
    if (wr_en) tags[waddr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (clr_en) begin
      valid[waddr] <= 1'b0;
    end else if (wr_en) begin
      valid[waddr] <= 1'b1;
    end
  end

  assign rtag   = tags[raddr];
  assign rvalid = valid[raddr];

`ifdef TAG_PARITY_EN
  logic par [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) par[waddr] <= ^din;
  end

  // Only a valid entry can report an error; stale garbage is not a fault.
  assign rperr = valid[raddr] & ((^tags[raddr]) != par[raddr]);
`endif

endmodule
`default_nettype wire

// File: rtl/icache_tag_store.sv
`default_nettype none
// ============================================================================
// icache_tag_store : set-associative I-cache tag store with tag compare and
// background flush; optional per-way tag parity with macro TAG_PARITY_EN. Rev 1.0
// ============================================================================
module icache_tag_store
  import icache_tag_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_WAYS   = DEF_NUM_WAYS
) (
  input  logic                           clk0,
  input  logic                           rst0_n,
  input  logic                           csb0,
  input  logic                           web0,
  input  logic [ADDR_WIDTH-1:0]          addr0,
  input  logic [NUM_WAYS-1:0]            wmask0,
  input  logic                           inv0,
  input  logic [DATA_WIDTH-1:0]          din0,
  input  logic                           flush0,
  output logic [NUM_WAYS*DATA_WIDTH-1:0] dout0,
  output logic [NUM_WAYS-1:0]            valid0,
  output logic [NUM_WAYS-1:0]            hit0,
`ifdef TAG_PARITY_EN
  output logic [NUM_WAYS-1:0]            perr0,
`endif
  output logic                           busy0
);

  state_t                        state, state_nxt;
  logic [ADDR_WIDTH-1:0]         cnt, cnt_nxt;
  logic                          access_ok, rd_req, wr_req, inv_req;
  logic [ADDR_WIDTH-1:0]         waddr;
  logic                          rd_pend;
  logic [ADDR_WIDTH-1:0]         raddr_q;
  logic [DATA_WIDTH-1:0]         cmp_q;
  logic [NUM_WAYS*DATA_WIDTH-1:0] rd_tags;
  logic [NUM_WAYS-1:0]           rd_valid, rd_hit, rd_perr;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy0     = 1'b0;
    case (state)
      IDLE: begin
        if (flush0) state_nxt = FLUSH;
      end
      FLUSH: begin
        busy0   = 1'b1;
        cnt_nxt = cnt + ADDR_WIDTH'(1);
        if (cnt == '1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A flush request in the same cycle takes priority over any access.
  assign access_ok = (state == IDLE) && !flush0 && !csb0;
  assign rd_req    = access_ok && web0;
  assign wr_req    = access_ok && !web0 && !inv0;
  assign inv_req   = access_ok && !web0 && inv0;
  assign waddr     = (state == FLUSH) ? cnt : addr0;

  generate
    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
      icache_tag_way #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
      ) u_way (
        .clk    (clk0),
        .rst_n  (rst0_n),
        .wr_en  (wr_req & wmask0[w]),
        .clr_en ((state == FLUSH) | (inv_req & wmask0[w])),
        .waddr  (waddr),
        .din    (din0),
        .raddr  (raddr_q),
        .rtag   (rd_tags[w*DATA_WIDTH +: DATA_WIDTH]),
`ifdef TAG_PARITY_EN
        .rperr  (rd_perr[w]),
`endif
        .rvalid (rd_valid[w])
      );

      assign rd_hit[w] = rd_valid[w] & ~rd_perr[w]
                       & (rd_tags[w*DATA_WIDTH +: DATA_WIDTH] == cmp_q);
    end
  endgenerate

`ifndef TAG_PARITY_EN
  assign rd_perr = '0;
`endif

  // Two-stage read: request captured first, array result registered next.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rd_pend <= 1'b0;
      raddr_q <= '0;
      cmp_q   <= '0;
      dout0   <= '0;
      valid0  <= '0;
      hit0    <= '0;
`ifdef TAG_PARITY_EN
      perr0   <= '0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rd_pend <= rd_req;
      if (rd_req) begin
        raddr_q <= addr0;
        cmp_q   <= din0;
      end
      if (rd_pend) begin
        dout0  <= rd_tags;
        valid0 <= rd_valid;
        hit0   <= rd_hit;
`ifdef TAG_PARITY_EN
        perr0  <= rd_perr;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_tag_store.sv
`default_nettype none
// ============================================================================
// tb_icache_tag_store : directed tests for icache_tag_store (parity part under TAG_PARITY_EN)
// Rev 1.0
// ============================================================================
module tb_icache_tag_store;
  import icache_tag_pkg::*;

  logic        clk0 = 1'b0;
  logic        rst0_n = 1'b0;
  logic        csb0 = 1'b1;
  logic        web0 = 1'b1;
  logic [3:0]  addr0 = '0;
  logic [1:0]  wmask0 = '0;
  logic        inv0 = 1'b0;
  way_tag_t    din0 = '0;
  logic        flush0 = 1'b0;
  logic [47:0] dout0;
  logic [1:0]  valid0, hit0;
  logic        busy0;
`ifdef TAG_PARITY_EN
  logic [1:0]  perr0;
`endif

  int errors = 0;
  int checks = 0;

  icache_tag_store dut (
    .clk0   (clk0),
    .rst0_n (rst0_n),
    .csb0   (csb0),
    .web0   (web0),
    .addr0  (addr0),
    .wmask0 (wmask0),
    .inv0   (inv0),
    .din0   (din0),
    .flush0 (flush0),
    .dout0  (dout0),
    .valid0 (valid0),
    .hit0   (hit0),
`ifdef TAG_PARITY_EN
    .perr0  (perr0),
`endif
    .busy0  (busy0)
  );

  always #5 clk0 = ~clk0;

  task automatic wr(input logic [3:0] a, input logic [1:0] m, input way_tag_t d, input logic inv);
    @(negedge clk0);
    csb0 = 1'b0; web0 = 1'b0; inv0 = inv; addr0 = a; wmask0 = m; din0 = d;
    @(negedge clk0);
    csb0 = 1'b1; web0 = 1'b1; inv0 = 1'b0; wmask0 = '0;
  endtask

  // Ends #1 after the second edge, when the read result is visible.
  task automatic rd(input logic [3:0] a, input way_tag_t d);
    @(negedge clk0);
    csb0 = 1'b0; web0 = 1'b1; addr0 = a; din0 = d;
    @(negedge clk0);
    csb0 = 1'b1;
    @(posedge clk0);
    #1;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy0); end
    checks++; if (valid0 !== 2'b00) begin errors++; $display("FAIL rst_valid got %b want 00", valid0); end
    checks++; if (dout0 !== 48'h0) begin errors++; $display("FAIL rst_dout got %h want 0", dout0); end
`ifdef TAG_PARITY_EN
    checks++; if (perr0 !== 2'b00) begin errors++; $display("FAIL rst_perr got %b want 00", perr0); end
`endif
    @(negedge clk0); rst0_n = 1'b1;
    rd(4'd3, 24'h0);
    checks++; if (valid0 !== 2'b00) begin errors++; $display("FAIL rd3_valid got %b want 00", valid0); end
    checks++; if (hit0 !== 2'b00) begin errors++; $display("FAIL rd3_hit got %b want 00", hit0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rd3_busy got %b want 0", busy0); end
  endtask

  task automatic test_write_read;
    wr(4'd5, 2'b01, 24'hABCDEF, 1'b0);
    rd(4'd5, 24'hABCDEF);
    checks++; if (dout0[23:0] !== 24'hABCDEF) begin errors++; $display("FAIL wr5_dout got %h want abcdef", dout0[23:0]); end
    checks++; if (valid0 !== 2'b01) begin errors++; $display("FAIL wr5_valid got %b want 01", valid0); end
    checks++; if (hit0 !== 2'b01) begin errors++; $display("FAIL wr5_hit got %b want 01", hit0); end
    rd(4'd5, 24'hABCDEE);
    checks++; if (hit0 !== 2'b00) begin errors++; $display("FAIL miss5_hit got %b want 00", hit0); end
    // latency: nothing after the sampling edge, result after the next one
    @(negedge clk0);
    csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd5; din0 = 24'hABCDEF;
    @(posedge clk0); #1;
    checks++; if (hit0 !== 2'b00) begin errors++; $display("FAIL lat_early got %b want 00", hit0); end
    @(negedge clk0); csb0 = 1'b1;
    @(posedge clk0); #1;
    checks++; if (hit0 !== 2'b01) begin errors++; $display("FAIL lat_late got %b want 01", hit0); end
    // a write must leave the output registers alone
    wr(4'd5, 2'b10, 24'h123456, 1'b0);
    repeat (2) @(posedge clk0); #1;
    checks++; if (valid0 !== 2'b01) begin errors++; $display("FAIL wr_hold got %b want 01", valid0); end
    rd(4'd5, 24'h123456);
    checks++; if (valid0 !== 2'b11) begin errors++; $display("FAIL wr5b_valid got %b want 11", valid0); end
    checks++; if (hit0 !== 2'b10) begin errors++; $display("FAIL wr5b_hit got %b want 10", hit0); end
    checks++; if (dout0 !== 48'h123456_ABCDEF) begin errors++; $display("FAIL wr5b_dout got %h want 123456abcdef", dout0); end
    // zero mask write and invalidate
    wr(4'd6, 2'b00, 24'h666666, 1'b0);
    rd(4'd6, 24'h666666);
    checks++; if (valid0 !== 2'b00) begin errors++; $display("FAIL mask0_wr got %b want 00", valid0); end
    wr(4'd5, 2'b00, 24'h0, 1'b1);
    rd(4'd5, 24'hABCDEF);
    checks++; if (valid0 !== 2'b11) begin errors++; $display("FAIL mask0_inv got %b want 11", valid0); end
  endtask

  task automatic test_invalidate;
    wr(4'd7, 2'b01, 24'h111111, 1'b0);
    wr(4'd7, 2'b10, 24'h222222, 1'b0);
    wr(4'd7, 2'b10, 24'h0, 1'b1);
    rd(4'd7, 24'h111111);
    checks++; if (valid0 !== 2'b01) begin errors++; $display("FAIL inv7_valid got %b want 01", valid0); end
    checks++; if (hit0 !== 2'b01) begin errors++; $display("FAIL inv7_hit got %b want 01", hit0); end
    checks++; if (dout0 !== 48'h222222_111111) begin errors++; $display("FAIL inv7_tags got %h want 222222111111", dout0); end
  endtask

  task automatic test_flush;
    int n;
    for (int i = 0; i < 16; i++) begin
      wr(4'(i), 2'b01, 24'h5A0000 + 24'(i), 1'b0);
      wr(4'(i), 2'b10, 24'hA50000 + 24'(i), 1'b0);
    end
    rd(4'd0, 24'h5A0000);
    checks++; if (hit0 !== 2'b01) begin errors++; $display("FAIL pre_flush_hit got %b want 01", hit0); end
    @(negedge clk0); flush0 = 1'b1;
    @(negedge clk0); flush0 = 1'b0;
    csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd0; din0 = 24'h0;
    n = 0;
    while (busy0 && n < 40) begin
      n++;
      @(negedge clk0);
    end
    csb0 = 1'b1;
    checks++; if (n !== 16) begin errors++; $display("FAIL flush_len got %0d want 16", n); end
    repeat (3) @(posedge clk0); #1;
    checks++; if (hit0 !== 2'b01 || valid0 !== 2'b11) begin
      errors++; $display("FAIL flush_rd_drop got hit=%b valid=%b want 01/11", hit0, valid0);
    end
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), 24'h5A0000 + 24'(i));
      checks++; if (valid0 !== 2'b00) begin errors++; $display("FAIL post_flush set %0d valid got %b want 00", i, valid0); end
    end
  endtask

  task automatic test_flush_collision;
    int n;
    @(negedge clk0);
    flush0 = 1'b1; csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd2; wmask0 = 2'b11; din0 = 24'h2A2A2A;
    @(negedge clk0);
    flush0 = 1'b0; csb0 = 1'b1; web0 = 1'b1; wmask0 = 2'b00;
    n = 0;
    while (busy0 && n < 40) begin
      n++;
      flush0 = (n == 4);
      @(negedge clk0);
    end
    flush0 = 1'b0;
    checks++; if (n !== 16) begin errors++; $display("FAIL reflush_len got %0d want 16", n); end
    rd(4'd2, 24'h2A2A2A);
    checks++; if (dout0 !== 48'hA50002_5A0002) begin errors++; $display("FAIL coll_tags got %h want a500025a0002", dout0); end
    checks++; if (hit0 !== 2'b00) begin errors++; $display("FAIL coll_hit got %b want 00", hit0); end
  endtask

  task automatic test_reset_mid_flush;
    wr(4'd4, 2'b11, 24'h444444, 1'b0);
    @(negedge clk0); flush0 = 1'b1;
    @(negedge clk0); flush0 = 1'b0;
    repeat (5) @(negedge clk0);
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy0); end
    #2 rst0_n = 1'b0;
    #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_abort got %b want 0", busy0); end
    @(negedge clk0); rst0_n = 1'b1;
    wr(4'd4, 2'b01, 24'h444444, 1'b0);
    rd(4'd4, 24'h444444);
    checks++; if (hit0 !== 2'b01 || busy0 !== 1'b0) begin
      errors++; $display("FAIL post_rst_access got hit=%b busy=%b want 01/0", hit0, busy0);
    end
  endtask

`ifdef TAG_PARITY_EN
  task automatic test_parity;
    wr(4'd9, 2'b11, 24'h0C0C0C, 1'b0);
    rd(4'd9, 24'h0C0C0C);
    checks++; if (perr0 !== 2'b00 || hit0 !== 2'b11) begin
      errors++; $display("FAIL par_clean got perr=%b hit=%b want 00/11", perr0, hit0);
    end
    dut.g_way[1].u_way.tags[9][0] = ~dut.g_way[1].u_way.tags[9][0];
    rd(4'd9, 24'h0C0C0C);
    checks++; if (perr0 !== 2'b10) begin errors++; $display("FAIL par_err got %b want 10", perr0); end
    checks++; if (hit0 !== 2'b01) begin errors++; $display("FAIL par_hit got %b want 01", hit0); end
  endtask
`endif

  initial begin
    test_reset;
    test_write_read;
    test_invalidate;
    test_flush;
    test_flush_collision;
    test_reset_mid_flush;
`ifdef TAG_PARITY_EN
    test_parity;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
